// File: rtl/firebird_regfile_sb.sv
// Register file with optional write-through bypass and a one-bit-per-register
// pending-write scoreboard that holds issue on RAW/WAW hazards.
module firebird_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(NREGS)-1:0]     raddr1,
  input  logic [$clog2(NREGS)-1:0]     raddr2,
  output logic [XLEN-1:0]              rdata1,
  output logic [XLEN-1:0]              rdata2,
  output logic                         rbusy1,
  output logic                         rbusy2,
  input  logic                         we,
  input  logic [$clog2(NREGS)-1:0]     waddr,
  input  logic [XLEN-1:0]              wdata,
  input  logic                         issue_valid,
  input  logic [$clog2(NREGS)-1:0]     issue_rd,
  output logic                         issue_ready,
  input  logic                         flush,
  output logic [$clog2(NREGS+1)-1:0]   busy_count
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS+1);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;

  logic wr_en;
  logic fwd1;
  logic fwd2;
  logic waw;
  logic fire;
  logic set_en;
  logic clr_en;
  logic inc;

  assign wr_en = we && (waddr != '0);
  assign fwd1  = (BYPASS != 0) && wr_en && (waddr == raddr1);
  assign fwd2  = (BYPASS != 0) && wr_en && (waddr == raddr2);

  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == '0)
      rdata1 = '0;
    else if (fwd1)
      rdata1 = wdata;
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if (raddr2 == '0)
      rdata2 = '0;
    else if (fwd2)
      rdata2 = wdata;
  end

  assign rbusy1 = busy[raddr1] && !fwd1;
  assign rbusy2 = busy[raddr2] && !fwd2;

  // The destination clear is sequential, so a same-cycle writeback always
  // resolves the WAW hazard regardless of whether data is forwarded.
  assign waw = busy[issue_rd] && !(we && (waddr == issue_rd));

  // Issue handshake: issue_ready is a pure function of the sources, the
  // destination and the writeback port; it never looks at issue_valid. An
  // instruction is accepted (fire) on a cycle where issue_valid and
  // issue_ready are both high and no flush is in progress.
  assign issue_ready = !rbusy1 && !rbusy2 && !waw;
  assign fire        = issue_valid && issue_ready && !flush;
  assign set_en      = fire && (issue_rd != '0);

  // A writeback clear that coincides with a new issue to the same register
  // is overridden by the set, so it does not count as a clear.
  assign clr_en = wr_en && busy[waddr] && !(set_en && (issue_rd == waddr));
  assign inc    = set_en && !busy[issue_rd];

  always_comb begin
    busy_next = busy;
    if (wr_en)
      busy_next[waddr] = 1'b0;
    if (set_en)
      busy_next[issue_rd] = 1'b1;
    if (flush)
      busy_next = '0;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    count_next = count_q + CW'(inc) - CW'(clr_en);
    if (flush)
      count_next = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= '0;
      count_q <= '0;
    end else begin
      busy    <= busy_next;
      count_q <= count_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  assign busy_count = count_q;

  logic unused_aw;
  assign unused_aw = (AW == 0);

endmodule

// File: tb/tb_firebird_regfile_sb.sv
// Bench for firebird_regfile_sb: one bypassing and one non-bypassing instance
// driven in lockstep and checked every cycle against an array-based model.
module tb_firebird_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  raddr1, raddr2, waddr, issue_rd;
  logic [31:0] wdata;
  logic        we, issue_valid, flush;

  logic [31:0] rdata1_a, rdata2_a, rdata1_n, rdata2_n;
  logic        rbusy1_a, rbusy2_a, rbusy1_n, rbusy2_n;
  logic        ready_a, ready_n;
  logic [5:0]  count_a, count_n;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_reg [32];
  bit          m_busy [2][32];

  always #5 clk = ~clk;

  firebird_regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_byp (
    .clk(clk), .reset(reset),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_a), .rdata2(rdata2_a),
    .rbusy1(rbusy1_a), .rbusy2(rbusy2_a),
    .we(we), .waddr(waddr), .wdata(wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(ready_a),
    .flush(flush), .busy_count(count_a)
  );

  firebird_regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_nob (
    .clk(clk), .reset(reset),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_n), .rdata2(rdata2_n),
    .rbusy1(rbusy1_n), .rbusy2(rbusy2_n),
    .we(we), .waddr(waddr), .wdata(wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(ready_n),
    .flush(flush), .busy_count(count_n)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (b = 1 bypass, b = 0 no bypass)
  function automatic logic [31:0] m_rdata(input int b, input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (b == 1 && we && waddr == a) return wdata;
    return m_reg[a];
  endfunction

  function automatic bit m_rbusy(input int b, input logic [4:0] a);
    return m_busy[b][a] && !(b == 1 && we && waddr == a);
  endfunction

  function automatic bit m_ready(input int b);
    bit waw_hold;
    waw_hold = m_busy[b][issue_rd] && !(we && waddr == issue_rd);
    return !m_rbusy(b, raddr1) && !m_rbusy(b, raddr2) && !waw_hold;
  endfunction

  function automatic int m_count(input int b);
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_busy[b][r]);
    return n;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_reg[r] = 32'h0;
      m_busy[0][r] = 1'b0;
      m_busy[1][r] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit f [2];
    for (int b = 0; b < 2; b++) f[b] = issue_valid && m_ready(b) && !flush;
    for (int b = 0; b < 2; b++) begin
      if (flush) begin
        for (int r = 0; r < 32; r++) m_busy[b][r] = 1'b0;
      end else begin
        if (we && waddr != 0) m_busy[b][waddr] = 1'b0;
        if (f[b] && issue_rd != 0) m_busy[b][issue_rd] = 1'b1;
      end
    end
    if (we && waddr != 0) m_reg[waddr] = wdata;
  endtask

  task automatic check_dut(input int b, input logic [31:0] r1, input logic [31:0] r2,
                           input logic b1, input logic b2, input logic rdy,
                           input logic [5:0] cnt);
    chk($sformatf("bp%0d_rdata1", b), r1, m_rdata(b, raddr1));
    chk($sformatf("bp%0d_rdata2", b), r2, m_rdata(b, raddr2));
    chk($sformatf("bp%0d_rbusy1", b), b1, m_rbusy(b, raddr1));
    chk($sformatf("bp%0d_rbusy2", b), b2, m_rbusy(b, raddr2));
    chk($sformatf("bp%0d_ready", b), rdy, m_ready(b));
    chk($sformatf("bp%0d_count", b), cnt, 64'(m_count(b)));
  endtask

  // Compare process: outputs settle by the falling edge, state moves on the rising.
  always @(negedge clk) begin
    if (!reset) begin
      check_dut(1, rdata1_a, rdata2_a, rbusy1_a, rbusy2_a, ready_a, count_a);
      check_dut(0, rdata1_n, rdata2_n, rbusy1_n, rbusy2_n, ready_n, count_n);
      model_step();
    end
  end

  // ---------------- driver
  task automatic drive(input bit w, input logic [4:0] wa, input logic [31:0] wd,
                       input bit iv, input logic [4:0] rd,
                       input logic [4:0] a1, input logic [4:0] a2, input bit fl);
    @(posedge clk);
    #1;
    we = w; waddr = wa; wdata = wd;
    issue_valid = iv; issue_rd = rd;
    raddr1 = a1; raddr2 = a2; flush = fl;
    #2;
  endtask

  initial begin
    reset = 1'b1;
    we = 0; waddr = 0; wdata = 0; issue_valid = 0; issue_rd = 0;
    raddr1 = 0; raddr2 = 0; flush = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state across every address
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 0, 5'(a), 5'(31 - a), 0);
      chk("rst_rdata1", rdata1_a, 0);
      chk("rst_rdata2", rdata2_n, 0);
      chk("rst_rbusy", {rbusy1_a, rbusy2_a, rbusy1_n, rbusy2_n}, 0);
      chk("rst_ready", {ready_a, ready_n}, 2'b11);
      chk("rst_count", {count_a, count_n}, 0);
    end

    // Same-cycle read of a write
    drive(1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 0);
    chk("byp_same_cycle", rdata1_a, 32'hDEADBEEF);
    chk("nob_same_cycle", rdata1_n, 32'h0);
    drive(0, 0, 0, 0, 0, 5, 0, 0);
    chk("byp_next_cycle", rdata1_a, 32'hDEADBEEF);
    chk("nob_next_cycle", rdata1_n, 32'hDEADBEEF);

    // RAW and WAW on x7
    drive(0, 0, 0, 1, 7, 0, 0, 0);
    chk("issue7_ready", {ready_a, ready_n}, 2'b11);
    drive(0, 0, 0, 1, 0, 0, 7, 0);
    chk("raw7_rbusy2", {rbusy2_a, rbusy2_n}, 2'b11);
    chk("raw7_ready", {ready_a, ready_n}, 2'b00);
    chk("raw7_count", {count_a, count_n}, {6'd1, 6'd1});
    drive(0, 0, 0, 1, 7, 0, 0, 0);
    chk("waw7_ready", {ready_a, ready_n}, 2'b00);
    drive(1, 7, 32'h77, 1, 0, 0, 7, 0);
    chk("wb7_byp", {ready_a, rbusy2_a}, 2'b10);
    chk("wb7_byp_data", rdata2_a, 32'h77);
    chk("wb7_nob", {ready_n, rbusy2_n}, 2'b01);
    drive(0, 0, 0, 1, 0, 0, 7, 0);
    chk("after7_count", {count_a, count_n}, 0);
    chk("after7_nob_ready", ready_n, 1);
    chk("after7_nob_data", rdata2_n, 32'h77);

    // Clear and set of x9 in the same cycle
    drive(0, 0, 0, 1, 9, 0, 0, 0);
    drive(1, 9, 32'h99, 1, 9, 0, 0, 0);
    chk("x9_ready", {ready_a, ready_n}, 2'b11);
    chk("x9_count_before", {count_a, count_n}, {6'd1, 6'd1});
    drive(0, 0, 0, 0, 0, 9, 0, 0);
    chk("x9_count_after", {count_a, count_n}, {6'd1, 6'd1});
    chk("x9_busy", {rbusy1_a, rbusy1_n}, 2'b11);
    chk("x9_data", {rdata1_a, rdata1_n}, {32'h99, 32'h99});
    drive(1, 9, 32'h999, 0, 0, 0, 0, 0);

    // Flush drops a same-cycle issue but keeps a same-cycle write
    drive(0, 0, 0, 1, 3, 0, 0, 0);
    drive(0, 0, 0, 1, 4, 0, 0, 0);
    drive(0, 0, 0, 1, 6, 0, 0, 0);
    drive(1, 10, 32'h55, 1, 8, 0, 0, 1);
    chk("flush_count_before", {count_a, count_n}, {6'd3, 6'd3});
    drive(0, 0, 0, 0, 0, 8, 10, 0);
    chk("flush_count_after", {count_a, count_n}, 0);
    chk("flush_x8_idle", {rbusy1_a, rbusy1_n}, 0);
    chk("flush_wdata", {rdata2_a, rdata2_n}, {32'h55, 32'h55});
    drive(0, 0, 0, 0, 0, 9, 5, 0);
    chk("flush_keeps_data", {rdata1_a, rdata2_n}, {32'h999, 32'hDEADBEEF});

    // x0 is hardwired
    drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
    chk("x0_rdata_same", {rdata1_a, rdata1_n}, 0);
    chk("x0_ready_same", {ready_a, ready_n}, 2'b11);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_rdata_next", {rdata1_a, rdata1_n}, 0);
    chk("x0_count", {count_a, count_n}, 0);
    chk("x0_ready_next", {ready_a, ready_n}, 2'b11);

    // Asynchronous reset mid-operation
    drive(0, 0, 0, 1, 3, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 3, 5, 0);
    chk("pre_rst_count", {count_a, count_n}, {6'd1, 6'd1});
    chk("pre_rst_busy", {rbusy1_a, rbusy1_n}, 2'b11);
    chk("pre_rst_data", rdata2_a, 32'hDEADBEEF);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_count", {count_a, count_n}, 0);
    chk("async_rst_busy", {rbusy1_a, rbusy1_n}, 0);
    chk("async_rst_data", {rdata2_a, rdata2_n}, 0);
    chk("async_rst_ready", {ready_a, ready_n}, 2'b11);
    model_clear();
    @(posedge clk);
    #1 reset = 1'b0;

    // Randomised traffic
    repeat (3000) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      for (int t = 0; t < 8; t++) begin
        if (m_busy[1][wa] || m_busy[0][wa]) break;
        wa = 5'($urandom_range(0, 31));
      end
      drive($urandom_range(0, 2) == 0, wa, $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            $urandom_range(0, 39) == 0);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/firebird_regfile_sb.md
# firebird_regfile_sb

Parametrised register file with write-through bypass and a per-register pending-write scoreboard for the pipelined Firebird core. It sits between decode/issue and writeback. It supplies two source operands per cycle. It tracks which destination registers have an in-flight write and holds issue (via `issue_ready`) on RAW/WAW hazards. Register 0 is hardwired to zero and is never busy.

## Interface
Parameters:
- `XLEN`, default 32: register data width.
- `NREGS`, default 32: number of architectural registers; must be a power of two, ≥ 2.
- `BYPASS`, default 1: 1 forwards same-cycle writeback data to reads; 0 disables forwarding.
- Derived localparams: `AW = $clog2(NREGS)`, `CW = $clog2(NREGS+1)`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all registers, busy bits and counter.
- `raddr1`, `raddr2`  in  AW  source register addresses.
- `rdata1`, `rdata2`  out  XLEN  source data, combinational.
- `rbusy1`, `rbusy2`  out  1  source has a pending write not satisfied this cycle.
- `we`  in  1  writeback enable.
- `waddr`  in  AW  writeback address.
- `wdata`  in  XLEN  writeback data.
- `issue_valid`  in  1  instruction wants to issue, with sources `raddr1`/`raddr2`.
- `issue_rd`  in  AW  destination of the issuing instruction; 0 means no destination.
- `issue_ready`  out  1  issue may proceed this cycle.
- `flush`  in  1  synchronous: clears all busy bits; data unchanged.
- `busy_count`  out  CW  number of registers currently busy.

## Operation
- Storage: `NREGS` × `XLEN` flops. Registers 1..NREGS-1 reset to 0.
- Register 0: writes are ignored, reads return 0, the busy bit is constant 0, and setting it is ignored.
- Write: when `we` and `waddr != 0`, `reg[waddr] <= wdata` and `busy[waddr] <= 0`. A write to a non-busy register is legal.
- Read, port n:
  - if `raddr_n == 0`, the result is 0;
  - else if `BYPASS` and `we` and `waddr == raddr_n`, the result is `wdata`;
  - else the result is `reg[raddr_n]`.
- `wclr[r] = we && waddr == r && BYPASS`.
- `rbusy_n = busy[raddr_n] && !wclr[raddr_n]`.
- `issue_ready = !rbusy1 && !rbusy2 && !(busy[issue_rd] && !(we && waddr == issue_rd))`. The WAW check ignores `BYPASS` because the clear is sequential. The result is independent of `issue_valid`.
- `fire = issue_valid && issue_ready && !flush`. When `fire` and `issue_rd != 0`, `busy[issue_rd] <= 1`.
- Simultaneous writeback clear and issue set on the same register: the set wins and the register stays busy.
- `flush`: next cycle every busy bit is 0 and `busy_count` is 0. A same-cycle issue is dropped. A same-cycle write still updates data.
- `busy_count`: registered. Each cycle it is updated by +1 for a fire that sets a non-busy bit and −1 for each busy bit cleared. The net of both can be 0. With `flush`, it loads 0. Invariant: `busy_count` equals the popcount of the busy bits.

## Timing
- Reset values: all registers 0, all busy bits 0, `busy_count` 0. `issue_ready` is 1. `rdata*` are 0 and `rbusy*` are 0 for any address.
- Reset asserted mid-operation clears everything immediately, independent of `clk`. Inputs are ignored while `reset` is high.
- Read latency is 0 (combinational). With `BYPASS`=1, a write is visible in the same cycle. With `BYPASS`=0, it is visible the cycle after the edge.
- The busy bit is set at the edge that ends the fire cycle. It is visible on `rbusy`/`issue_ready` the following cycle.
- Writeback to a busy source in cycle N:
  - `BYPASS`=1: `issue_ready`=1 in cycle N.
  - `BYPASS`=0: `issue_ready`=1 in N+1.
- There is no multi-pending tracking per register. A WAW hazard holds issue, so at most one write is outstanding per register.

## Test plan
- Reset, then read all addresses: every `rdata` is 0, `rbusy` is 0, `issue_ready`=1, `busy_count`=0. Assert `reset` mid-burst: state clears with no clock edge.
- Write x5=0xDEADBEEF while reading raddr1=5 in the same cycle:
  - `BYPASS`=1: `rdata1`=0xDEADBEEF in that cycle.
  - `BYPASS`=0: old value 0 in that cycle, 0xDEADBEEF the next.
- Issue rd=7, then issue with raddr2=7: `rbusy2`=1 and `issue_ready`=0 until writeback of x7. `busy_count` goes 1→0. Check WAW issue rd=7 is held likewise.
- Same cycle: writeback x9 clears and issue rd=9 fires. Next cycle `busy[9]`=1 and `busy_count` is unchanged.
- Issue rd=3, 4, 6, so `busy_count`=3, then `flush` with `issue_valid` rd=8: next cycle `busy_count`=0, x8 not busy, data unchanged.
- Write x0=0xFFFFFFFF and issue rd=0: `rdata` for x0 stays 0, `busy_count` stays 0, `issue_ready` stays 1.
